icon_overlay_sel: RTL

//  Parametrised icon overlay source for the ISP video path. Places a W x H icon at a

---
 rtl/icon_overlay_pkg.sv | 29 ++
 rtl/icon_skin_rom.sv | 41 ++++
 rtl/icon_overlay_sel.sv | 123 ++++++++++++
 3 files changed

// File: rtl/icon_overlay_pkg.sv
// +----------------------------------------------------------------------------+
// | icon_overlay_pkg : shared types and helpers for the icon overlay source     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package icon_overlay_pkg;

  // Skin state: SKIN_OFF disables the overlay, SKIN_k selects ROM skin k.
  typedef enum logic [2:0] {
    SKIN_OFF = 3'd0,
    SKIN_0   = 3'd1,
    SKIN_1   = 3'd2,
    SKIN_2   = 3'd3,
    SKIN_3   = 3'd4,
    SKIN_4   = 3'd5,
    SKIN_5   = 3'd6,
    SKIN_6   = 3'd7
  } skin_e;

  localparam int PIPE_LAT = 2;

  function automatic int calc_addr_w(input int n, input int w, input int h);
    return $clog2(n * w * h);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icon_skin_rom.sv
// +----------------------------------------------------------------------------+
// | icon_skin_rom : single-port synchronous ROM holding every skin back to back |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module icon_skin_rom #(
  parameter int          DEPTH      = 10000,
  parameter int          DW         = 24,
  parameter int          AW         = 14,
  parameter logic [DW-1:0] TRANSP_KEY = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);

  // Built-in image: an address ramp with the MSB set; every word whose low
  // address bits are 3'b101 is punched out to the transparent key colour.
  function automatic logic [DW-1:0] image_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    if (32'(a) >= DEPTH) begin
      w = '0;
    end else if (a[2:0] == 3'd5) begin
      w = TRANSP_KEY;
    end else begin
      w         = DW'(a);
      w[DW-1]   = 1'b1;
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= image_word(addr);
  end

endmodule

`default_nettype wire

// File: rtl/icon_overlay_sel.sv
// +----------------------------------------------------------------------------+
// | icon_overlay_sel : positioned multi-skin icon source for the overlay mixer  |
// | Option macro: ICON_TRANSPARENT_EN (key-colour pixels report no hit)         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module icon_overlay_sel
  import icon_overlay_pkg::*;
#(
  parameter int            ICON_W     = 50,
  parameter int            ICON_H     = 50,
  parameter int            NUM_SKIN   = 4,
  parameter int            DW         = 24,
  parameter int            XW         = 12,
  parameter logic [DW-1:0] TRANSP_KEY = 24'h000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] pixel_x,
  input  logic [XW-1:0] pixel_y,
  input  logic          de,
  input  logic [XW-1:0] pos_x,
  input  logic [XW-1:0] pos_y,
  input  logic          key,
  output logic [2:0]    skin_sel,
  output logic          hit,
  output logic          de_o,
  output logic [DW-1:0] data_o
);

  localparam int          c_area      = ICON_W * ICON_H;
  localparam int          c_addr_w    = calc_addr_w(NUM_SKIN, ICON_W, ICON_H);
  localparam skin_e       c_last_skin = skin_e'(3'(NUM_SKIN));
  localparam logic [XW:0] c_w_lim     = (XW+1)'(ICON_W);
  localparam logic [XW:0] c_h_lim     = (XW+1)'(ICON_H);

  skin_e                r_pending, w_pending_nxt, r_skin, w_skin;
  logic [XW-1:0]        r_x0, r_y0, w_x0, w_y0;
  logic                 w_fs, w_in_win;
  logic [XW:0]          w_dx, w_dy;
  logic [c_addr_w-1:0]  w_addr, r_addr;
  logic                 r_win1, r_win2;
  logic [PIPE_LAT-1:0]  r_de_pipe;
  logic [DW-1:0]        w_rom_q;

  assign w_fs = de && (pixel_x == '0) && (pixel_y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= SKIN_OFF;
    else        r_pending <= w_pending_nxt;
  end

  always_comb begin
    w_pending_nxt = r_pending;
    if (key) begin
      if (r_pending == c_last_skin) w_pending_nxt = SKIN_OFF;
      else                          w_pending_nxt = skin_e'(3'(r_pending) + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skin <= SKIN_OFF;
      r_x0   <= '0;
      r_y0   <= '0;
    end else if (w_fs) begin
      r_skin <= r_pending;
      r_x0   <= pos_x;
      r_y0   <= pos_y;
    end
  end

  // The frame-start pixel itself already belongs to the new frame.
  assign w_skin = w_fs ? r_pending : r_skin;
  assign w_x0   = w_fs ? pos_x     : r_x0;
  assign w_y0   = w_fs ? pos_y     : r_y0;

  // One extra bit makes px < X0 wrap to a huge offset, which fails the compare.
  assign w_dx     = {1'b0, pixel_x} - {1'b0, w_x0};
  assign w_dy     = {1'b0, pixel_y} - {1'b0, w_y0};
  assign w_in_win = de && (w_skin != SKIN_OFF) && (w_dx < c_w_lim) && (w_dy < c_h_lim);
  assign w_addr   = c_addr_w'(32'(3'(w_skin) - 3'd1) * c_area + 32'(w_dy) * ICON_W + 32'(w_dx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_win1    <= 1'b0;
      r_win2    <= 1'b0;
      r_de_pipe <= '0;
    end else begin
      r_addr    <= w_addr;
      r_win1    <= w_in_win;
      r_win2    <= r_win1;
      r_de_pipe <= {r_de_pipe[PIPE_LAT-2:0], de};
    end
  end

  icon_skin_rom #(
    .DEPTH      (NUM_SKIN * c_area),
    .DW         (DW),
    .AW         (c_addr_w),
    .TRANSP_KEY (TRANSP_KEY)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (r_addr),
    .q     (w_rom_q)
  );

`ifdef ICON_TRANSPARENT_EN
  assign hit = r_win2 && (w_rom_q != TRANSP_KEY);
`else
  assign hit = r_win2;
`endif

  assign data_o   = hit ? w_rom_q : '0;
  assign de_o     = r_de_pipe[PIPE_LAT-1];
  assign skin_sel = 3'(r_skin);

endmodule

`default_nettype wire
